regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a built-in busy-bit scoreboard. It is the next-generation replacement for the single-write, two-read register file in the CPU core. It adds configurable width, depth and port counts, multiple writeback ports with deterministic conflict resolution, and optional write-to-read bypass. It also tracks pending writes so that issue logic can tell whether each read operand is ready.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file and its busy-bit
// scoreboard: default geometry, the x0 index and the address width helper.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    // Architectural zero register: always reads 0, never becomes busy.
    localparam int ZERO_REG  = 0;

    // Address width needed to index a file of n registers (n is a power of two).
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Busy-bit vector tracking registers with an outstanding producer.
//   clk, rst        clock, asynchronous active-low reset
//   we, wa          write-port enables and addresses (a write clears busy)
//   rsv_en/rsv_addr reserve request (sets busy)
//   flush           clears the whole vector on the next edge
//   busy            registered busy vector, bit 0 always 0
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = NWR_DEF,
    parameter int AW    = addr_width(NREGS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] set;
    logic [NREGS-1:0] busy_next;

    // Priority: flush > reserve > write-clear. The reserve is OR-ed in after
    // the clear mask so a same-cycle write cannot cancel the new producer.
    always_comb begin
        clr       = '0;
        set       = '0;
        busy_next = '0;
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) begin
                clr[wa[k*AW +: AW]] = 1'b1;
            end
        end
        if (rsv_en) begin
            set[rsv_addr] = 1'b1;
        end
        if (!flush) begin
            busy_next = (busy & ~clr) | set;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port register file with optional write-to-read bypass
// and a busy-bit scoreboard for operand readiness.
//   clk, rst        clock, asynchronous active-low reset
//   we, wa, wd      NWR write ports (packed, port k at [k*W +: W])
//   ra              NRD read addresses
//   rd              NRD read data, combinational
//   rd_rdy          per read port: operand has no pending producer
//   rsv_en/rsv_addr reserve a register (mark busy)
//   flush           clear all busy bits
//   busy            registered busy vector
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NWR    = NWR_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_rdy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy
);

    logic [XLEN-1:0] regs [NREGS];

    logic [AW-1:0]   rd_addr [NRD];
    logic [XLEN-1:0] fwd     [NRD];
    logic [NRD-1:0]  hit;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy)
    );

    // Ports are visited in ascending order, so when several ports target the
    // same register the last (highest-indexed) non-blocking update wins.
    // Writes to x0 are dropped; its storage stays at the reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (wa[k*AW +: AW] != AW'(ZERO_REG))) begin
                    regs[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes. The forwarding search uses the same ascending scan so the
    // bypassed value matches what storage will hold after the edge. While
    // reset is asserted the outputs are forced to their idle values so that
    // any write presented during reset is not forwarded.
    always_comb begin
        rd     = '0;
        rd_rdy = '1;
        hit    = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_addr[p] = ra[p*AW +: AW];
            fwd[p]     = '0;
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (wa[k*AW +: AW] == rd_addr[p])) begin
                    hit[p] = 1'b1;
                    fwd[p] = wd[k*XLEN +: XLEN];
                end
            end
            if (rst && (rd_addr[p] != AW'(ZERO_REG))) begin
                if ((BYPASS != 0) && hit[p]) begin
                    rd[p*XLEN +: XLEN] = fwd[p];
                end else begin
                    rd[p*XLEN +: XLEN] = regs[rd_addr[p]];
                end
                rd_rdy[p] = !busy[rd_addr[p]] || ((BYPASS != 0) && hit[p]);
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and
// compares both against an architectural model of the register file.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NRD*AW-1:0]   ra;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;

    logic [NRD*XLEN-1:0] rd_byp, rd_nob;
    logic [NRD-1:0]      rdy_byp, rdy_nob;
    logic [NREGS-1:0]    busy_byp, busy_nob;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_byp), .rd_rdy(rdy_byp), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy(busy_byp)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_nob), .rd_rdy(rdy_nob), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy(busy_nob)
    );

    // Architectural model state.
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    int checks = 0;
    int fails  = 0;

    function automatic logic [XLEN-1:0] m_rd(input int a, input bit byp);
        logic [XLEN-1:0] v;
        if (!rst || a == 0) return '0;
        v = m_regs[a];
        if (byp) begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && int'(wa[k*AW +: AW]) == a) v = wd[k*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    function automatic logic m_rdy(input int a, input bit byp);
        if (!rst || a == 0) return 1'b1;
        if (byp) begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && int'(wa[k*AW +: AW]) == a) return 1'b1;
            end
        end
        return !m_busy[a];
    endfunction

    function automatic logic [NREGS-1:0] m_busy_vec();
        logic [NREGS-1:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // One clock edge of the architectural rules.
    task automatic m_step();
        logic nb [NREGS];
        for (int r = 1; r < NREGS; r++) begin
            bit written;
            bit reserved;
            written  = 0;
            reserved = rsv_en && int'(rsv_addr) == r;
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && int'(wa[k*AW +: AW]) == r) begin
                    written   = 1;
                    m_regs[r] = wd[k*XLEN +: XLEN];
                end
            end
            if (flush)         nb[r] = 1'b0;
            else if (reserved) nb[r] = 1'b1;
            else if (written)  nb[r] = 1'b0;
            else               nb[r] = m_busy[r];
        end
        for (int r = 1; r < NREGS; r++) m_busy[r] = nb[r];
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we       = '0;
        wa       = '0;
        wd       = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we[k]              = 1'b1;
        wa[k*AW +: AW]     = a;
        wd[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        ra = '0;
        m_reset();
        repeat (2) @(negedge clk);
        for (int a = 0; a < NREGS; a++) begin
            set_ra(0, AW'(a));
            set_ra(1, AW'(NREGS - 1 - a));
            #1;
            checks++;
            if (rd_byp !== '0 || rd_nob !== '0) begin
                fails++;
                $display("[TB] FAIL reset_rd addr=%0d got byp=%h nob=%h want 0", a, rd_byp, rd_nob);
            end
            checks++;
            if (rdy_byp !== '1 || rdy_nob !== '1) begin
                fails++;
                $display("[TB] FAIL reset_rdy addr=%0d got byp=%b nob=%b want 11", a, rdy_byp, rdy_nob);
            end
        end
        checks++;
        if (busy_byp !== '0 || busy_nob !== '0) begin
            fails++;
            $display("[TB] FAIL reset_busy got byp=%h nob=%h want 0", busy_byp, busy_nob);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_conflict();
        idle_inputs();
        set_wr(0, 5, 64'h1111);
        set_wr(1, 5, 64'h2222);
        set_ra(0, 5);
        set_ra(1, 0);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_byp[0 +: XLEN] !== 64'h2222 || rd_nob[0 +: XLEN] !== 64'h2222) begin
            fails++;
            $display("[TB] FAIL conflict_x5 got byp=%h nob=%h want 2222", rd_byp[0 +: XLEN], rd_nob[0 +: XLEN]);
        end
        set_wr(0, 0, 64'hFFFF);
        set_ra(0, 0);
        #1;
        checks++;
        if (rd_byp[0 +: XLEN] !== '0) begin
            fails++;
            $display("[TB] FAIL x0_bypass got %h want 0", rd_byp[0 +: XLEN]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_byp[0 +: XLEN] !== '0 || rd_nob[0 +: XLEN] !== '0) begin
            fails++;
            $display("[TB] FAIL x0_write got byp=%h nob=%h want 0", rd_byp[0 +: XLEN], rd_nob[0 +: XLEN]);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        set_wr(0, 7, 64'h1234);
        tick();
        idle_inputs();
        set_wr(1, 7, 64'hABCD);
        set_ra(1, 7);
        #1;
        checks++;
        if (rd_byp[XLEN +: XLEN] !== 64'hABCD) begin
            fails++;
            $display("[TB] FAIL bypass_same_cycle got %h want abcd", rd_byp[XLEN +: XLEN]);
        end
        checks++;
        if (rd_nob[XLEN +: XLEN] !== 64'h1234) begin
            fails++;
            $display("[TB] FAIL nobypass_old got %h want 1234", rd_nob[XLEN +: XLEN]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_nob[XLEN +: XLEN] !== 64'hABCD || rd_byp[XLEN +: XLEN] !== 64'hABCD) begin
            fails++;
            $display("[TB] FAIL bypass_next_cycle got byp=%h nob=%h want abcd", rd_byp[XLEN +: XLEN], rd_nob[XLEN +: XLEN]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rsv_en   = 1'b1;
        rsv_addr = 3;
        set_ra(0, 3);
        #1;
        checks++;
        if (busy_nob[3] !== 1'b0 || rdy_nob[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reserve_early got busy=%b rdy=%b want 0/1", busy_nob[3], rdy_nob[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy_byp[3] !== 1'b1 || busy_nob[3] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reserve_busy got byp=%b nob=%b want 1", busy_byp[3], busy_nob[3]);
        end
        checks++;
        if (rdy_byp[0] !== 1'b0 || rdy_nob[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reserve_rdy got byp=%b nob=%b want 0", rdy_byp[0], rdy_nob[0]);
        end
        tick();
        set_wr(0, 3, 64'h3333);
        #1;
        checks++;
        if (rdy_byp[0] !== 1'b1 || rdy_nob[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL write_cycle_rdy got byp=%b nob=%b want 1/0", rdy_byp[0], rdy_nob[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy_byp[3] !== 1'b0 || busy_nob[3] !== 1'b0 || rdy_byp[0] !== 1'b1 || rdy_nob[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL write_clear got busy=%b/%b rdy=%b/%b want 0/0 1/1",
                     busy_byp[3], busy_nob[3], rdy_byp[0], rdy_nob[0]);
        end
    endtask

    task automatic test_rsv_priority();
        idle_inputs();
        rsv_en   = 1'b1;
        rsv_addr = 4;
        set_wr(1, 4, 64'h4444);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy_byp[4] !== 1'b1 || busy_nob[4] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rsv_beats_write got byp=%b nob=%b want 1", busy_byp[4], busy_nob[4]);
        end
        rsv_en   = 1'b1;
        rsv_addr = 9;
        flush    = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy_byp !== '0 || busy_nob !== '0) begin
            fails++;
            $display("[TB] FAIL flush_beats_rsv got byp=%h nob=%h want 0", busy_byp, busy_nob);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            for (int k = 0; k < NWR; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_wr(k, AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1)),
                           {$urandom, $urandom});
                end
            end
            for (int p = 0; p < NRD; p++) begin
                set_ra(p, AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1)));
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(ra[p*AW +: AW]);
                checks++;
                if (rd_byp[p*XLEN +: XLEN] !== m_rd(a, 1'b1) || rd_nob[p*XLEN +: XLEN] !== m_rd(a, 1'b0)) begin
                    fails++;
                    $display("[TB] FAIL rand_rd cyc=%0d port=%0d got %h/%h want %h/%h", i, p,
                             rd_byp[p*XLEN +: XLEN], rd_nob[p*XLEN +: XLEN], m_rd(a, 1'b1), m_rd(a, 1'b0));
                end
                checks++;
                if (rdy_byp[p] !== m_rdy(a, 1'b1) || rdy_nob[p] !== m_rdy(a, 1'b0)) begin
                    fails++;
                    $display("[TB] FAIL rand_rdy cyc=%0d port=%0d got %b/%b want %b/%b", i, p,
                             rdy_byp[p], rdy_nob[p], m_rdy(a, 1'b1), m_rdy(a, 1'b0));
                end
            end
            checks++;
            if (busy_byp !== m_busy_vec() || busy_nob !== m_busy_vec()) begin
                fails++;
                $display("[TB] FAIL rand_busy cyc=%0d got %h/%h want %h", i, busy_byp, busy_nob, m_busy_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        rsv_en   = 1'b1;
        rsv_addr = 3;
        tick();
        idle_inputs();
        set_wr(0, 3, 64'h5555);
        set_wr(1, 12, 64'h6666);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        checks++;
        if (busy_byp !== '0 || busy_nob !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_busy got byp=%h nob=%h want 0", busy_byp, busy_nob);
        end
        for (int a = 0; a < NREGS; a += 2) begin
            set_ra(0, AW'(a));
            set_ra(1, AW'(a + 1));
            #1;
            checks++;
            if (rd_byp !== '0 || rd_nob !== '0 || rdy_byp !== '1 || rdy_nob !== '1) begin
                fails++;
                $display("[TB] FAIL midreset_rd addr=%0d got rd=%h/%h rdy=%b/%b want 0 and 11",
                         a, rd_byp, rd_nob, rdy_byp, rdy_nob);
            end
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        set_wr(0, 10, 64'hCAFE);
        tick();
        idle_inputs();
        set_ra(0, 10);
        set_ra(1, 3);
        #1;
        checks++;
        if (rd_byp[0 +: XLEN] !== 64'hCAFE || rd_nob[0 +: XLEN] !== 64'hCAFE) begin
            fails++;
            $display("[TB] FAIL post_reset_write got %h/%h want cafe", rd_byp[0 +: XLEN], rd_nob[0 +: XLEN]);
        end
        checks++;
        if (rd_byp[XLEN +: XLEN] !== '0 || rd_nob[XLEN +: XLEN] !== '0 || busy_byp !== '0 || busy_nob !== '0) begin
            fails++;
            $display("[TB] FAIL post_reset_x3 got rd=%h/%h busy=%h/%h want 0",
                     rd_byp[XLEN +: XLEN], rd_nob[XLEN +: XLEN], busy_byp, busy_nob);
        end
        @(negedge clk);
    endtask

    // Prints the stored contents of every register through read port 0.
    task automatic dump_regs();
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            set_ra(0, AW'(a));
            #1;
            $display("[TB] x%0d = %h busy=%b", a, rd_nob[0 +: XLEN], busy_nob[a]);
        end
    endtask

    initial begin
        rst = 1'b0;
        ra  = '0;
        idle_inputs();
        test_reset();
        test_write_conflict();
        test_bypass();
        test_scoreboard();
        test_rsv_priority();
        test_random(400);
        test_reset_mid();
        test_random(200);
        dump_regs();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
